// File: rtl/dcnn_pkg.sv
// dcnn_pkg: shared row-stream widths, receiver state encoding and width helper.
package dcnn_pkg;
  localparam int ROW_W_DEF = 480;
  localparam int WORD_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} rr_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/row_assembler.sv
// row_assembler: shifts words into a row register (first word ends up on top) and counts words.
module row_assembler import dcnn_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              clr,
  input  logic [WORD_W-1:0] data,
  output logic [ROW_W-1:0]  row,
  output logic              last_word
);
  localparam int WPR = ROW_W / WORD_W;
  localparam int CW = clog2(WPR);
  localparam logic [CW-1:0] LAST = CW'(WPR - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift) begin
      row <= (row << WORD_W) | ROW_W'(data);
      cnt <= cnt + 1'b1;
    end
  end
  assign last_word = cnt == LAST;
endmodule

// File: rtl/row_receiver.sv
// row_receiver: reassembles streamed words into image rows and writes them to the row buffer.
// Optional even-parity checking with sticky err when ROW_PARITY_EN is defined.
module row_receiver import dcnn_pkg::*; #(
  parameter int ROW_W = ROW_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int IMG_ROWS = 30
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
`ifdef ROW_PARITY_EN
  input  logic                        in_parity,
  output logic                        err,
`endif
  output logic                        in_ready,
  output logic                        row_we,
  output logic [clog2(IMG_ROWS)-1:0]  row_addr,
  output logic [ROW_W-1:0]            row_data,
  output logic                        done,
  output logic                        stop
);
  localparam int AW = clog2(IMG_ROWS);
  localparam logic [AW-1:0] LAST_ROW = AW'(IMG_ROWS - 1);
  rr_state_t state, state_n;
  logic [AW-1:0] row_cnt;
  logic arm, shift, clr, last_word, done_q, more_rows;
  row_assembler #(.WORD_W(WORD_W), .ROW_W(ROW_W)) u_asm (
    .clk(clk),
    .rst(rst),
    .shift(shift),
    .clr(clr),
    .data(in_data),
    .row(row_data),
    .last_word(last_word)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    arm = start && (state == IDLE || state == DONE);
    shift = state == RECV && in_valid;
    more_rows = row_cnt != LAST_ROW;
    clr = arm || (state == WRITE && more_rows);
    state_n = arm ? RECV :
              (shift && last_word) ? WRITE :
              state == WRITE ? (more_rows ? RECV : DONE) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == WRITE && !more_rows;
      row_cnt <= arm ? '0 : (state == WRITE && more_rows) ? row_cnt + 1'b1 : row_cnt;
    end
  end
`ifdef ROW_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || arm) err <= 1'b0;
    else if (shift && ^{in_data, in_parity}) err <= 1'b1;
  end
`endif
  assign in_ready = state == RECV;
  assign row_we = state == WRITE;
  assign row_addr = row_cnt;
  assign done = done_q;
  assign stop = state == DONE;
endmodule

// File: tb/tb_row_receiver.sv
// tb_row_receiver: scoreboard bench; drivers queue expected row writes, a monitor checks each row_we.
module tb_row_receiver;
  localparam int WPR = 30;
  localparam int NR = 30;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [15:0] in_data = '0;
  logic in_ready, row_we, done, stop;
  logic [4:0] row_addr;
  logic [479:0] row_data;
`ifdef ROW_PARITY_EN
  logic in_parity = 0, err;
`endif
  row_receiver dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
`ifdef ROW_PARITY_EN
    .in_parity(in_parity), .err(err),
`endif
    .in_ready(in_ready), .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
    .done(done), .stop(stop)
  );
  always #5 clk = ~clk;
  typedef struct { logic [4:0] addr; logic [479:0] data; } row_t;
  row_t q[$];
  row_t e;
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_we = -1, s = 0;
  bit cont = 0;
  always @(posedge clk) cyc++;
  task automatic chk(string name, logic [479:0] act, logic [479:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] word(int img, int r, int w);
    return 16'((img << 12) | (r << 5) | w);
  endfunction
  function automatic logic [479:0] mk_row(int img, int r);
    logic [479:0] v;
    v = '0;
    for (int w = 0; w < WPR; w++) v = (v << 16) | 480'(word(img, r, w));
    return v;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (row_we) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_row_we: addr %0d written, no row expected", row_addr);
        end else begin
          e = q.pop_front();
          chk("row_addr", 480'(row_addr), 480'(e.addr));
          chk("row_data", row_data, e.data);
        end
        chk("in_ready_in_write", 480'(in_ready), 480'(0));
        if (cont && last_we >= 0) chk("row_spacing", 480'(cyc - last_we), 480'(31));
        last_we = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask
  task automatic put(logic [15:0] d, bit bad, int gap);
    repeat (gap) @(negedge clk);
    in_valid = 1;
    in_data = d;
`ifdef ROW_PARITY_EN
    in_parity = (^d) ^ bad;
`endif
    for (int n = 0; !in_ready; n++) begin
      if (n > 200) begin
        $display("FAIL accept_timeout: in_ready 0, expected 1");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic send_row(int img, int r, int n, bit bursty, int bad_w);
    if (n == WPR) q.push_back('{5'(r), mk_row(img, r)});
    for (int w = 0; w < n; w++) begin
      put(word(img, r, w), w == bad_w, bursty ? int'($urandom_range(0, 2)) : 0);
`ifdef ROW_PARITY_EN
      if (w == bad_w) chk("err_after_bad_word", 480'(err), 480'(1));
`endif
    end
  endtask
  task automatic arm();
    start = 1;
    s = cyc;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_stop();
    for (int n = 0; !stop; n++) begin
      if (n > 200) begin
        $display("FAIL stop_timeout: stop 0, expected 1");
        errors++;
        checks++;
        finish_run();
      end
      @(negedge clk);
    end
    #1;
  endtask
  task automatic reset_checks();
    chk("rst_in_ready", 480'(in_ready), 480'(0));
    chk("rst_row_we", 480'(row_we), 480'(0));
    chk("rst_row_addr", 480'(row_addr), 480'(0));
    chk("rst_row_data", row_data, 480'(0));
    chk("rst_done", 480'(done), 480'(0));
    chk("rst_stop", 480'(stop), 480'(0));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 0;
    @(negedge clk);
    // image 1, continuous; a word offered alongside start must not be consumed
    cont = 1;
    last_we = -1;
    in_valid = 1;
    in_data = 16'hdead;
    arm();
    in_valid = 0;
`ifdef ROW_PARITY_EN
    chk("err_clear_at_start", 480'(err), 480'(0));
`endif
    for (int r = 0; r < NR; r++) send_row(1, r, WPR, 0, -1);
    wait_stop();
    chk("done_latency", 480'(done_cyc - s), 480'(931));
    chk("done_count_1", 480'(done_cnt), 480'(1));
    @(negedge clk);
    chk("done_one_cycle", 480'(done), 480'(0));
    chk("stop_held", 480'(stop), 480'(1));
    // re-arm from DONE, bursty upstream, start pulsed mid-image
    cont = 0;
    arm();
    chk("stop_after_rearm", 480'(stop), 480'(0));
    for (int r = 0; r < NR; r++) begin
      send_row(1, r, WPR, 1, -1);
      if (r == 4) begin
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
      end
    end
    wait_stop();
    chk("done_count_2", 480'(done_cnt), 480'(2));
    // reset after two rows plus seven words
    arm();
    send_row(2, 0, WPR, 0, -1);
    send_row(2, 1, WPR, 0, -1);
    send_row(2, 2, 7, 0, -1);
    rst = 1;
    @(negedge clk);
    reset_checks();
    rst = 0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 480'(in_ready), 480'(0));
    // fresh image after reset, with one corrupted parity word when enabled
    cont = 1;
    last_we = -1;
    arm();
    for (int r = 0; r < NR; r++) send_row(3, r, WPR, 0, (r == 3) ? 5 : -1);
    wait_stop();
    chk("done_latency_2", 480'(done_cyc - s), 480'(931));
    chk("done_count_3", 480'(done_cnt), 480'(3));
`ifdef ROW_PARITY_EN
    chk("err_sticky", 480'(err), 480'(1));
    arm();
    chk("err_cleared_by_start", 480'(err), 480'(0));
`endif
    chk("queue_drained", 480'(q.size()), 480'(0));
    finish_run();
  end
endmodule

// File: doc/row_receiver.md
# row_receiver

Accelerator-side receive stage that sits directly downstream of the row transmitter (`sendRow`). It accepts the serialized image stream word by word over a valid/ready handshake and reassembles each 480-bit image row, MSB word first. It writes each completed row into the image row buffer at a sequential row address. When the last row of an image has been written, it pulses `done` and holds `stop` high, so the host side ceases reading rows.

## Interface
Parameters:
- `ROW_W`, 480: bits per image row.
- `WORD_W`, 16: bits per transfer word; `ROW_W` must be an integer multiple of `WORD_W`.
- `IMG_ROWS`, 30: rows per image.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle strobe that arms reception of a new image.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WORD_W  upstream word.
- `in_parity`  in  1  even-parity bit for `in_data`; present only with `ROW_PARITY_EN`.
- `in_ready`  out  1  word accepted on a cycle where `in_valid && in_ready`.
- `row_we`  out  1  one-cycle row-buffer write strobe.
- `row_addr`  out  clog2(IMG_ROWS)  row index, 0-based.
- `row_data`  out  ROW_W  assembled row.
- `done`  out  1  one-cycle pulse after the last row is written.
- `stop`  out  1  high from the `done` pulse until the next `start`.
- `err`  out  1  sticky parity error; present only with `ROW_PARITY_EN`.

## Operation
- Derived constant: `WPR = ROW_W / WORD_W` (30 at the defaults).
- FSM states:
  - IDLE: `in_ready` = 0. `start` → RECV; clears the word count, row count and `err`.
  - RECV: `in_ready` = 1. Each accepted word shifts into the row register at the top slice, so the first word ends up in `row_data[ROW_W-1 -: WORD_W]`. Accepting word `WPR-1` → WRITE.
  - WRITE: `in_ready` = 0. `row_we` = 1 with `row_addr` = the current row count. If the row count equals `IMG_ROWS-1` → DONE; otherwise the row count increments, the word count clears, and the FSM returns to RECV.
  - DONE: `in_ready` = 0, `stop` = 1. `done` is high only on the first DONE cycle. `start` → RECV, re-armed exactly as from IDLE.
- `start` is ignored in RECV and WRITE.
- `in_valid` outside RECV is ignored; no word is consumed.
- Word counter width is clog2(WPR). Row counter width is clog2(IMG_ROWS). Neither counter wraps: both are cleared explicitly.
- `row_data` holds its value between writes. It is valid only while `row_we` = 1.
- Reset values:
  - state = IDLE
  - `in_ready` = 0, `row_we` = 0, `row_addr` = 0, `row_data` = 0
  - `done` = 0, `stop` = 0, `err` = 0
- Reset mid-image discards the partial row and all row progress. No `row_we` is issued for a partial row.

## Timing
- Accepting up to one word per cycle gives minimum row latency: final word accepted in cycle N, `row_we` in cycle N+1, first word of the next row acceptable in cycle N+2.
- Minimum image duration from `start` is `IMG_ROWS*(WPR+1)+1` cycles, with `done` in the final cycle.
- `in_ready` is a registered function of state only. It never depends combinationally on `in_valid`.
- Upstream may drop `in_valid` at any cycle. The word count holds until transfers resume.
- `rst` wins over every other input in the same cycle.
- `start` together with `in_valid` in IDLE: only the transition to RECV occurs; the word is not consumed.

## Configuration
- `ROW_PARITY_EN` defined:
  - `in_parity` and `err` exist.
  - On each accepted word, `^{in_data, in_parity}` = 1 sets `err`. `err` is sticky until `start` or `rst`.
  - The word is still stored and the row is still written; `err` is a flag only.
- `ROW_PARITY_EN` undefined: both ports and all parity logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `dcnn_pkg`:
  - `ROW_W` and `WORD_W` defaults.
  - The `rr_state_t` enum (IDLE, RECV, WRITE, DONE).
  - A clog2 helper for counter widths.
- Sub-module `row_assembler`:
  - Parameterized `WORD_W`/`ROW_W` shift register plus word counter.
  - Inputs: shift enable and clear. Outputs: the row and a `last_word` flag.
  - The top level holds the FSM, the row counter, the output registers and the parity logic.

## Test plan
- Single row: `IMG_ROWS`=1; `start`; stream words 0x0001..0x001E back-to-back. Expect `row_we` one cycle after the 30th word, `row_addr`=0, `row_data[479:464]`=0x0001, `row_data[15:0]`=0x001E, `done` one cycle later, `stop` held high.
- Full image at defaults with continuous `in_valid`. Expect 30 `row_we` pulses at addresses 0..29 spaced 31 cycles apart, `done` exactly 931 cycles after `start`, and `in_ready` low in every WRITE cycle.
- Bursty upstream: random `in_valid` gaps. Expect row contents identical to the continuous case and no word lost or duplicated.
- Reset mid-image: `rst` after 2 rows plus 7 words, then `start` and a full image. Expect `row_addr` restarting at 0, no spurious `row_we`, and all outputs at reset values in the reset cycle.
- Re-arm: `start` while in DONE. Expect `stop` low the next cycle and a second image received normally. `start` pulsed in RECV has no effect.
- With `ROW_PARITY_EN`: corrupt the parity of word 5 of row 3. Expect `err` high from the cycle after that word, the row still written, and `err` cleared by the next `start`.
